// File: rtl/lpf_writer_pkg.sv
// Shared widths, FIFO word type and filter arithmetic for the LPF write path.
// Width macros normally come from params.v; the fallbacks below keep this slice self-contained.
`ifndef LOG_WIDTH
`define LOG_WIDTH 10
`endif
`ifndef LOG_HEIGHT
`define LOG_HEIGHT 9
`endif
`ifndef LOG_TRUNC
`define LOG_TRUNC 8
`endif
`ifndef LOG_MEM
`define LOG_MEM 16
`endif
`ifndef IMAGE_WIDTH
`define IMAGE_WIDTH 640
`endif
`ifndef LPF_FIFO_DEPTH
`define LPF_FIFO_DEPTH 4
`endif

package lpf_writer_pkg;
  localparam int LW = `LOG_WIDTH;
  localparam int LH = `LOG_HEIGHT;
  localparam int TW = `LOG_TRUNC;
  localparam int MW = `LOG_MEM;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [LW-1:0] x;
    logic [LH-1:0] y;
    logic [MW-1:0] data;
  } lpf_word_t;

  // (p[x-2] + 2*p[x-1] + p[x] + 2) >> 2; the TW+2 bit sum cannot overflow
  function automatic logic [TW-1:0] lpf_tap3(input logic [TW-1:0] pm2,
                                             input logic [TW-1:0] pm1,
                                             input logic [TW-1:0] p0);
    logic [TW+1:0] sum;
    sum = {2'b00, pm2} + {1'b0, pm1, 1'b0} + {2'b00, p0} + {{TW{1'b0}}, 2'b10};
    return sum[TW+1:2];
  endfunction
endpackage

// File: rtl/lpf_word_fifo.sv
// Small synchronous FIFO of packed {x, y, data} words; push and pop may coincide, even when full.
module lpf_word_fifo
  import lpf_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  lpf_word_t word_i,
  output lpf_word_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  lpf_word_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == {(PTR_W+1){1'b0}});
  assign push_ok_s = push_i && (!full_o || pop_i);
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // storage array
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= word_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1'b1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/lpf_writer.sv
// LPF frame writer: 3-tap horizontal filter, even/odd pixel pairing, word FIFO and write FSM.
// Define LPF_FILTER_EN to enable the filter; otherwise pixels pass through with the same latency.
module lpf_writer
  import lpf_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = `LPF_FIFO_DEPTH,
  parameter int PTR_W      = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_flag,
  input  logic [TW-1:0] pixel_in,
  input  logic [LW-1:0] x_in,
  input  logic [LH-1:0] y_in,
  input  logic          pixel_in_flag,
  output logic          lpf_flag,
  output logic          lpf_wr,
  output logic [LW-1:0] lpf_x,
  output logic [LH-1:0] lpf_y,
  output logic [MW-1:0] lpf_pixel_write,
  input  logic          done_lpf,
  output logic          overflow
);
  logic [TW-1:0] filt_d;
  logic [TW-1:0] filt_q;
  logic          filt_valid_q;
  logic [LW-1:0] filt_x_q;
  logic [LH-1:0] filt_y_q;

`ifdef LPF_FILTER_EN
  logic [TW-1:0] hist1_q;
  logic [TW-1:0] hist2_q;
  logic [TW-1:0] tap1_s;
  logic [TW-1:0] tap2_s;

  // x==0 replicates the edge pixel into both taps; x==1 then sees p[0] twice naturally
  always_comb begin
    tap1_s = hist1_q;
    tap2_s = hist2_q;
    if (x_in == {LW{1'b0}}) begin
      tap1_s = pixel_in;
      tap2_s = pixel_in;
    end else if (frame_flag) begin
      tap1_s = {TW{1'b0}};
      tap2_s = {TW{1'b0}};
    end else begin
      tap1_s = hist1_q;
      tap2_s = hist2_q;
    end
  end

  // row history shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      hist1_q <= {TW{1'b0}};
      hist2_q <= {TW{1'b0}};
    end else if (pixel_in_flag) begin
      hist2_q <= tap1_s;
      hist1_q <= pixel_in;
    end else if (frame_flag) begin
      hist1_q <= {TW{1'b0}};
      hist2_q <= {TW{1'b0}};
    end
  end

  always_comb filt_d = lpf_tap3(tap2_s, tap1_s, pixel_in);
`else
  always_comb filt_d = pixel_in;
`endif

  // filter output register
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_valid_q <= 1'b0;
      filt_q       <= {TW{1'b0}};
      filt_x_q     <= {LW{1'b0}};
      filt_y_q     <= {LH{1'b0}};
    end else begin
      filt_valid_q <= pixel_in_flag;
      if (pixel_in_flag) begin
        filt_q   <= filt_d;
        filt_x_q <= x_in;
        filt_y_q <= y_in;
      end
    end
  end

  logic [TW-1:0] even_q;
  logic [LW-1:0] even_x_q;
  logic [LH-1:0] even_y_q;
  logic          even_valid_q;
  logic          push_s;
  logic          pop_s;
  lpf_word_t     push_word_s;
  lpf_word_t     head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  wr_state_e     state_q;

  // an odd pixel completes a word only if its even neighbour on the same row is held
  assign push_s = filt_valid_q && filt_x_q[0] && even_valid_q && !frame_flag &&
                  (even_x_q == {filt_x_q[LW-1:1], 1'b0}) && (even_y_q == filt_y_q);
  assign push_word_s = '{x: even_x_q, y: even_y_q, data: {even_q, filt_q}};
  assign pop_s = (state_q == WR_WAIT) && done_lpf;

  // even pixel holding register
  always_ff @(posedge clock) begin
    if (reset) begin
      even_valid_q <= 1'b0;
      even_q       <= {TW{1'b0}};
      even_x_q     <= {LW{1'b0}};
      even_y_q     <= {LH{1'b0}};
    end else if (frame_flag) begin
      even_valid_q <= 1'b0;
    end else if (filt_valid_q && !filt_x_q[0]) begin
      even_valid_q <= 1'b1;
      even_q       <= filt_q;
      even_x_q     <= filt_x_q;
      even_y_q     <= filt_y_q;
    end
  end

  lpf_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .word_i  (push_word_s),
    .head_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // sticky drop indicator
  always_ff @(posedge clock) begin
    if (reset || frame_flag) begin
      overflow <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow <= 1'b1;
    end
  end

  logic          lpf_flag_q;
  logic          lpf_wr_q;
  logic [LW-1:0] lpf_x_q;
  logic [LH-1:0] lpf_y_q;
  logic [MW-1:0] lpf_data_q;

  // write transaction FSM; the head word stays in the FIFO until done_lpf pops it
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= WR_IDLE;
      lpf_flag_q <= 1'b0;
      lpf_wr_q   <= 1'b0;
      lpf_x_q    <= {LW{1'b0}};
      lpf_y_q    <= {LH{1'b0}};
      lpf_data_q <= {MW{1'b0}};
    end else begin
      case (state_q)
        WR_IDLE: begin
          if (!fifo_empty_s) begin
            lpf_x_q    <= head_s.x;
            lpf_y_q    <= head_s.y;
            lpf_data_q <= head_s.data;
            lpf_flag_q <= 1'b1;
            lpf_wr_q   <= 1'b1;
            state_q    <= WR_WAIT;
          end else begin
            lpf_flag_q <= 1'b0;
          end
        end
        WR_WAIT: begin
          lpf_flag_q <= 1'b0;
          if (done_lpf) begin
            lpf_wr_q <= 1'b0;
            state_q  <= WR_IDLE;
          end
        end
        default: begin
          lpf_flag_q <= 1'b0;
          lpf_wr_q   <= 1'b0;
          state_q    <= WR_IDLE;
        end
      endcase
    end
  end

  assign lpf_flag        = lpf_flag_q;
  assign lpf_wr          = lpf_wr_q;
  assign lpf_x           = lpf_x_q;
  assign lpf_y           = lpf_y_q;
  assign lpf_pixel_write = lpf_data_q;
endmodule

// File: tb/tb_lpf_writer.sv
// Self-checking bench for lpf_writer: row vector table plus overflow, reset and frame sequences.
module tb_lpf_writer;
  import lpf_writer_pkg::*;

  logic          clock;
  logic          reset;
  logic          frame_flag;
  logic [TW-1:0] pixel_in;
  logic [LW-1:0] x_in;
  logic [LH-1:0] y_in;
  logic          pixel_in_flag;
  logic          lpf_flag;
  logic          lpf_wr;
  logic [LW-1:0] lpf_x;
  logic [LH-1:0] lpf_y;
  logic [MW-1:0] lpf_pixel_write;
  logic          done_lpf;
  logic          overflow;
  logic          done_auto;
  logic          done_man;
  logic          resp_en;

  int total;
  int bad;
  int flag_count;
  lpf_word_t exp_q[$];

  assign done_lpf = done_auto | done_man;

  lpf_writer dut (
    .clock           (clock),
    .reset           (reset),
    .frame_flag      (frame_flag),
    .pixel_in        (pixel_in),
    .x_in            (x_in),
    .y_in            (y_in),
    .pixel_in_flag   (pixel_in_flag),
    .lpf_flag        (lpf_flag),
    .lpf_wr          (lpf_wr),
    .lpf_x           (lpf_x),
    .lpf_y           (lpf_y),
    .lpf_pixel_write (lpf_pixel_write),
    .done_lpf        (done_lpf),
    .overflow        (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0][TW-1:0] p;
    logic [1:0][MW-1:0] ef;
    logic [1:0][MW-1:0] eu;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int f0h, input int f0l, input int f1h, input int f1l,
                              input int u0h, input int u0l, input int u1h, input int u1l);
    vec_t v;
    v.p[0]  = TW'(a);
    v.p[1]  = TW'(b);
    v.p[2]  = TW'(c);
    v.p[3]  = TW'(d);
    v.ef[0] = {TW'(f0h), TW'(f0l)};
    v.ef[1] = {TW'(f1h), TW'(f1l)};
    v.eu[0] = {TW'(u0h), TW'(u0l)};
    v.eu[1] = {TW'(u1h), TW'(u1l)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic pix(input int x, input int y, input int p);
    x_in          = LW'(x);
    y_in          = LH'(y);
    pixel_in      = TW'(p);
    pixel_in_flag = 1'b1;
    @(negedge clock);
    pixel_in_flag = 1'b0;
  endtask

  task automatic exp_push(input int x, input int y, input logic [MW-1:0] d);
    lpf_word_t w;
    w.x    = LW'(x);
    w.y    = LH'(y);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || lpf_wr) && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    chk(name, exp_q.size(), 0);
  endtask

  // done_lpf responder: two cycles after a write is seen open
  initial begin
    done_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (resp_en && lpf_wr && !reset) begin
        repeat (2) @(negedge clock);
        done_auto = 1'b1;
        @(negedge clock);
        done_auto = 1'b0;
      end
    end
  end

  // write monitor: scoreboard compare on each request, stability check during WAIT
  initial begin : monitor
    lpf_word_t     e;
    logic [LW-1:0] hx;
    logic [LH-1:0] hy;
    logic [MW-1:0] hd;
    hx = '0;
    hy = '0;
    hd = '0;
    forever begin
      @(negedge clock);
      if (!reset && lpf_flag) begin
        flag_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got x=%0d y=%0d data=%h expected no write",
                   lpf_x, lpf_y, lpf_pixel_write);
        end else begin
          e = exp_q.pop_front();
          chk("write_x", 32'(lpf_x), 32'(e.x));
          chk("write_y", 32'(lpf_y), 32'(e.y));
          chk("write_data", 32'(lpf_pixel_write), 32'(e.data));
          chk("write_wr", 32'(lpf_wr), 32'd1);
        end
        hx = lpf_x;
        hy = lpf_y;
        hd = lpf_pixel_write;
      end else if (!reset && lpf_wr) begin
        chk("wait_stable_x", 32'(lpf_x), 32'(hx));
        chk("wait_stable_y", 32'(lpf_y), 32'(hy));
        chk("wait_stable_data", 32'(lpf_pixel_write), 32'(hd));
      end
    end
  end

  vec_t vecs[5];
  logic [1:0][MW-1:0] ew;
  int fc0;

  initial begin
    total = 0;
    bad = 0;
    flag_count = 0;
    reset = 1'b1;
    frame_flag = 1'b0;
    pixel_in_flag = 1'b0;
    pixel_in = '0;
    x_in = '0;
    y_in = '0;
    done_man = 1'b0;
    resp_en = 1'b1;

    //            pixels            filtered words      pass-through words
    vecs[0] = mk(8, 8, 8, 8,       8, 8, 8, 8,         8, 8, 8, 8);
    vecs[1] = mk(0, 0, 16, 0,      0, 0, 4, 8,         0, 0, 16, 0);
    vecs[2] = mk(255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
    vecs[3] = mk(100, 0, 0, 0,     100, 75, 25, 0,     100, 0, 0, 0);
    vecs[4] = mk(0, 0, 0, 200,     0, 0, 0, 50,        0, 0, 0, 200);

    repeat (3) @(negedge clock);
    chk("reset_flag", 32'(lpf_flag), 32'd0);
    chk("reset_wr", 32'(lpf_wr), 32'd0);
    chk("reset_x", 32'(lpf_x), 32'd0);
    chk("reset_y", 32'(lpf_y), 32'd0);
    chk("reset_data", 32'(lpf_pixel_write), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 5; i++) begin
`ifdef LPF_FILTER_EN
      ew = vecs[i].ef;
`else
      ew = vecs[i].eu;
`endif
      for (int k = 0; k < 4; k++) begin
        pix(k, 10 + i, int'(vecs[i].p[k]));
        if (k == 1) exp_push(0, 10 + i, ew[0]);
        if (k == 3) exp_push(2, 10 + i, ew[1]);
      end
      wait_drain("table_drain");
    end

    // odd pixel with no matching even neighbour
    fc0 = flag_count;
    pix(5, 3, 77);
    repeat (12) @(negedge clock);
    chk("odd_no_push", flag_count, fc0);
    chk("odd_no_wr", 32'(lpf_wr), 32'd0);

    // overflow with done_lpf held low
    resp_en = 1'b0;
    for (int x = 0; x < 12; x++) begin
      pix(x, 5, 40);
      if ((x % 2 == 1) && (x < 8)) exp_push(x - 1, 5, {TW'(40), TW'(40)});
    end
    repeat (3) @(negedge clock);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_wr_open", 32'(lpf_wr), 32'd1);
    chk("ovf_x_head", 32'(lpf_x), 32'd0);

    // reset while a write is open
    reset = 1'b1;
    @(negedge clock);
    chk("rst_wait_flag", 32'(lpf_flag), 32'd0);
    chk("rst_wait_wr", 32'(lpf_wr), 32'd0);
    chk("rst_wait_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    fc0 = flag_count;
    done_man = 1'b1;
    @(negedge clock);
    done_man = 1'b0;
    resp_en = 1'b1;
    repeat (12) @(negedge clock);
    chk("rst_fifo_empty", flag_count, fc0);
    chk("rst_done_ignored_wr", 32'(lpf_wr), 32'd0);

    // frame_flag with words queued and overflow set
    resp_en = 1'b0;
    for (int x = 0; x < 12; x++) begin
      pix(x, 6, 20);
      if ((x % 2 == 1) && (x < 8)) exp_push(x - 1, 6, {TW'(20), TW'(20)});
    end
    repeat (3) @(negedge clock);
    chk("frame_ovf_before", 32'(overflow), 32'd1);
    frame_flag = 1'b1;
    @(negedge clock);
    frame_flag = 1'b0;
    chk("frame_ovf_cleared", 32'(overflow), 32'd0);
    resp_en = 1'b1;
    wait_drain("frame_queued_drain");

    // pixel arriving with frame_flag starts the new frame
    frame_flag = 1'b1;
    pix(0, 8, 60);
    frame_flag = 1'b0;
    pix(1, 8, 60);
    exp_push(0, 8, {TW'(60), TW'(60)});
    wait_drain("frame_new_row_drain");
    chk("final_overflow", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
